// File: rtl/ula_control.sv
// -----------------------------------------------------------------------------
// ula_control
//
// Multi-cycle control FSM for the 16-bit ALU (ula) datapath on the shared bus.
// The FSM loads an instruction word from din into IR and decodes it. It then
// drives the datapath control signals one step at a time.
//
// Instruction word: {op[15:13], rx[12:10], ry[9:7], unused[6:0]}
//   ADD 000, SUB 001, NAN 010 : DECODE -> EXEC -> WB      (rx <- rx op ry)
//   OUT 100                   : DECODE only (rx to output port)
//   LDI 101                   : DECODE only (rx <- din, sampled during DECODE)
//   REP 111                   : DECODE only (rx <- ry)
//   011 / 110                 : NOP, done in DECODE
//
// Ports
//   clock      in   1      system clock, all state on the rising edge
//   resetn     in   1      synchronous reset, active-low
//   run        in   1      start; sampled only in IDLE
//   din        in   16     instruction word (and the LDI immediate in DECODE)
//   ir_in      out  1      load IR from din (run & IDLE, gated by resetn)
//   rin        out  NREG   one-hot register write enable
//   rout       out  NREG   one-hot register drive-bus enable
//   din_out    out  1      drive din onto the bus
//   a_in       out  1      load ALU operand register A
//   g_in       out  1      load ALU result register G
//   g_out      out  1      drive G onto the bus
//   out_en     out  1      strobe the bus value to the output port
//   op_select  out  OPW    ALU opSelect (3'b111 = pass A when idle)
//   done       out  1      one-cycle pulse in the last cycle of an instruction
//   busy       out  1      high whenever the FSM is not in IDLE
//   icount     out  16     instructions retired, saturating (ULA_CTRL_ICOUNT_EN)
//
// Optional feature: define ULA_CTRL_ICOUNT_EN to add the icount port and its
// counter. Without the macro the port and the counter are absent.
//
// Handshake: a run pulse is accepted only in a cycle where busy=0. The
// instruction on din is captured in that same cycle. A run seen while busy=1
// is dropped and is not queued. The next run can be accepted in the cycle
// after done.
//
// All datapath outputs are registered. Each output is computed from the next
// state and the next IR value, so it appears in the cycle the FSM sits in that
// state. ir_in is the one combinational output, because it must follow run
// within the IDLE cycle.
// -----------------------------------------------------------------------------
module ula_control #(
    parameter int NREG = 8,
    parameter int OPW  = 3
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            run,
    input  logic [15:0]     din,
    output logic            ir_in,
    output logic [NREG-1:0] rin,
    output logic [NREG-1:0] rout,
    output logic            din_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic            out_en,
    output logic [OPW-1:0]  op_select,
    output logic            done,
    output logic            busy
`ifdef ULA_CTRL_ICOUNT_EN
    ,
    output logic [15:0]     icount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_REP = 3'b111;

    // Only IR[15:7] carries information; the low bits are never decoded.
    state_t          r_state;
    logic [15:7]     r_ir;
    logic [NREG-1:0] r_rin;
    logic [NREG-1:0] r_rout;
    logic            r_din_out;
    logic            r_a_in;
    logic            r_g_in;
    logic            r_g_out;
    logic            r_out_en;
    logic [OPW-1:0]  r_op_select;
    logic            r_done;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [15:7]     w_ir_nxt;
    logic [2:0]      w_op;
    logic [NREG-1:0] w_rx_oh;
    logic [NREG-1:0] w_ry_oh;
    logic [NREG-1:0] w_rin;
    logic [NREG-1:0] w_rout;
    logic            w_din_out;
    logic            w_a_in;
    logic            w_g_in;
    logic            w_g_out;
    logic            w_out_en;
    logic [OPW-1:0]  w_op_select;
    logic            w_done;
    logic            w_unused_din;

    assign w_unused_din = &{1'b0, din[6:0]};

    // Next state and next IR.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_ir_nxt    = din[15:7];
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_ir[15:13] == OP_ADD || r_ir[15:13] == OP_SUB ||
                    r_ir[15:13] == OP_NAN)
                    w_state_nxt = S_EXEC;
                else
                    w_state_nxt = S_IDLE;
            end
            S_EXEC:  w_state_nxt = S_WB;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_op    = w_ir_nxt[15:13];
    assign w_rx_oh = {{(NREG-1){1'b0}}, 1'b1} << w_ir_nxt[12:10];
    assign w_ry_oh = {{(NREG-1){1'b0}}, 1'b1} << w_ir_nxt[9:7];

    // Output values for the state the FSM is about to enter.
    always_comb begin
        w_rin       = '0;
        w_rout      = '0;
        w_din_out   = 1'b0;
        w_a_in      = 1'b0;
        w_g_in      = 1'b0;
        w_g_out     = 1'b0;
        w_out_en    = 1'b0;
        w_op_select = OPW'(3'b111);
        w_done      = 1'b0;
        case (w_state_nxt)
            S_DECODE: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_NAN: begin
                        w_rout = w_rx_oh;
                        w_a_in = 1'b1;
                    end
                    OP_LDI: begin
                        w_din_out = 1'b1;
                        w_rin     = w_rx_oh;
                        w_done    = 1'b1;
                    end
                    OP_REP: begin
                        w_rout = w_ry_oh;
                        w_rin  = w_rx_oh;
                        w_done = 1'b1;
                    end
                    OP_OUT: begin
                        w_rout   = w_rx_oh;
                        w_out_en = 1'b1;
                        w_done   = 1'b1;
                    end
                    default: w_done = 1'b1;   // NOP
                endcase
            end
            S_EXEC: begin
                w_rout      = w_ry_oh;
                w_g_in      = 1'b1;
                w_op_select = OPW'(w_op);
            end
            S_WB: begin
                w_g_out = 1'b1;
                w_rin   = w_rx_oh;
                w_done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_rin       <= '0;
            r_rout      <= '0;
            r_din_out   <= 1'b0;
            r_a_in      <= 1'b0;
            r_g_in      <= 1'b0;
            r_g_out     <= 1'b0;
            r_out_en    <= 1'b0;
            r_op_select <= OPW'(3'b111);
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ir        <= w_ir_nxt;
            r_rin       <= w_rin;
            r_rout      <= w_rout;
            r_din_out   <= w_din_out;
            r_a_in      <= w_a_in;
            r_g_in      <= w_g_in;
            r_g_out     <= w_g_out;
            r_out_en    <= w_out_en;
            r_op_select <= w_op_select;
            r_done      <= w_done;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef ULA_CTRL_ICOUNT_EN
    // The count steps on the same edge that raises done, so the new value is
    // visible during the done cycle.
    logic [15:0] r_icount;

    always_ff @(posedge clock) begin
        if (!resetn)
            r_icount <= '0;
        else if (w_done && r_icount != 16'hFFFF)
            r_icount <= r_icount + 16'd1;
    end

    assign icount = r_icount;
`endif

    assign ir_in     = run & resetn & (r_state == S_IDLE);
    assign rin       = r_rin;
    assign rout      = r_rout;
    assign din_out   = r_din_out;
    assign a_in      = r_a_in;
    assign g_in      = r_g_in;
    assign g_out     = r_g_out;
    assign out_en    = r_out_en;
    assign op_select = r_op_select;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ula_control.sv
// Bench for ula_control. Each driver step sets the inputs for one clock cycle.
// It also pushes the output vector that is expected during that cycle. A
// separate monitor pops one entry and compares it on every falling edge.
// Vector layout:
//   {ir_in, rin[7:0], rout[7:0], din_out, a_in, g_in, g_out, out_en,
//    op_select[2:0], done, busy}
module tb_ula_control;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        din_out;
  logic        a_in;
  logic        g_in;
  logic        g_out;
  logic        out_en;
  logic [2:0]  op_select;
  logic        done;
  logic        busy;
`ifdef ULA_CTRL_ICOUNT_EN
  logic [15:0] icount;
  logic [15:0] icnt_model;
`endif

  logic [26:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;

  ula_control dut (
    .clock     (clock),
    .resetn    (resetn),
    .run       (run),
    .din       (din),
    .ir_in     (ir_in),
    .rin       (rin),
    .rout      (rout),
    .din_out   (din_out),
    .a_in      (a_in),
    .g_in      (g_in),
    .g_out     (g_out),
    .out_en    (out_en),
    .op_select (op_select),
    .done      (done),
    .busy      (busy)
`ifdef ULA_CTRL_ICOUNT_EN
    ,
    .icount    (icount)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  // fl = {din_out, a_in, g_in, g_out, out_en}
  function automatic logic [26:0] ev(input logic ii, input logic [7:0] ri,
                                     input logic [7:0] ro, input logic [4:0] fl,
                                     input logic [2:0] op, input logic dn,
                                     input logic bs);
    return {ii, ri, ro, fl, op, dn, bs};
  endfunction

  function automatic logic [26:0] idle_v(input logic ii);
    return ev(ii, 8'h00, 8'h00, 5'b00000, 3'b111, 1'b0, 1'b0);
  endfunction

  task automatic step(input string nm, input logic rn, input logic r,
                      input logic [15:0] d, input logic [26:0] e);
    @(posedge clock);
    #1;
    resetn = rn;
    run    = r;
    din    = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [26:0] got;
    logic [26:0] want;
    string       nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {ir_in, rin, rout, din_out, a_in, g_in, g_out, out_en,
                op_select, done, busy};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL %s: got=%07h want=%07h", nm, got, want);
        end
`ifdef ULA_CTRL_ICOUNT_EN
        if (want[1] && icnt_model != 16'hFFFF) icnt_model = icnt_model + 16'd1;
        total++;
        if (icount !== icnt_model) begin
          bad++;
          $display("FAIL icount_%s: got=%04h want=%04h", nm, icount, icnt_model);
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    run    = 1'b0;
    din    = 16'h0000;
`ifdef ULA_CTRL_ICOUNT_EN
    icnt_model = 16'h0000;
`endif
    // Two reset edges before any check.
    @(posedge clock);
    @(posedge clock);

    // Reset state; ir_in gated by resetn even with run high.
    step("rst_gate", 1'b0, 1'b1, 16'h0500, idle_v(1'b0));
    step("rst_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // ADD r1,r2; din garbage while busy must be ignored.
    step("add_run",  1'b1, 1'b1, 16'h0500, idle_v(1'b1));
    step("add_dec",  1'b1, 1'b0, 16'hFFFF, ev(0, 8'h00, 8'h02, 5'b01000, 3'b111, 0, 1));
    step("add_exe",  1'b1, 1'b0, 16'hFFFF, ev(0, 8'h00, 8'h04, 5'b00100, 3'b000, 0, 1));
    step("add_wb",   1'b1, 1'b0, 16'h0000, ev(0, 8'h02, 8'h00, 5'b00010, 3'b111, 1, 1));
    step("add_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // Reset for two cycles while ADD is in EXEC: abandoned, no done.
    step("rm_run",   1'b1, 1'b1, 16'h0500, idle_v(1'b1));
    step("rm_dec",   1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h02, 5'b01000, 3'b111, 0, 1));
    step("rm_exe",   1'b0, 1'b0, 16'h0000, ev(0, 8'h00, 8'h04, 5'b00100, 3'b000, 0, 1));
    step("rm_rst2",  1'b0, 1'b1, 16'h0500, idle_v(1'b0));
    step("rm_after", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));
    step("rm_quiet", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // LDI r7, immediate 1234 on din during DECODE.
    step("ldi_run",  1'b1, 1'b1, 16'hBC00, idle_v(1'b1));
    step("ldi_dec",  1'b1, 1'b0, 16'h1234, ev(0, 8'h80, 8'h00, 5'b10000, 3'b111, 1, 1));
    step("ldi_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // REP r0<-r5 then OUT r4 back-to-back; run during DECODE ignored.
    step("rep_run",  1'b1, 1'b1, 16'hE280, idle_v(1'b1));
    step("rep_dec",  1'b1, 1'b1, 16'h9000, ev(0, 8'h01, 8'h20, 5'b00000, 3'b111, 1, 1));
    step("out_run",  1'b1, 1'b1, 16'h9000, idle_v(1'b1));
    step("out_dec",  1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h10, 5'b00001, 3'b111, 1, 1));
    step("out_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // SUB r1,r1 with run held high; next instruction (NOP 011) picked up in IDLE.
    step("sub_run",  1'b1, 1'b1, 16'h2480, idle_v(1'b1));
    step("sub_dec",  1'b1, 1'b1, 16'h2480, ev(0, 8'h00, 8'h02, 5'b01000, 3'b111, 0, 1));
    step("sub_exe",  1'b1, 1'b1, 16'h2480, ev(0, 8'h00, 8'h02, 5'b00100, 3'b001, 0, 1));
    step("sub_wb",   1'b1, 1'b1, 16'h6000, ev(0, 8'h02, 8'h00, 5'b00010, 3'b111, 1, 1));
    step("nop_run",  1'b1, 1'b1, 16'h6000, idle_v(1'b1));
    step("nop_dec",  1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h00, 5'b00000, 3'b111, 1, 1));
    step("nop_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // NAN r6,r3.
    step("nan_run",  1'b1, 1'b1, 16'h5980, idle_v(1'b1));
    step("nan_dec",  1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h40, 5'b01000, 3'b111, 0, 1));
    step("nan_exe",  1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h08, 5'b00100, 3'b010, 0, 1));
    step("nan_wb",   1'b1, 1'b0, 16'h0000, ev(0, 8'h40, 8'h00, 5'b00010, 3'b111, 1, 1));

    // NOP opcode 110.
    step("nop6_run", 1'b1, 1'b1, 16'hC000, idle_v(1'b1));
    step("nop6_dec", 1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h00, 5'b00000, 3'b111, 1, 1));
    step("nop6_idl", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d entries pending want=0", exp_q.size());
    end

`ifdef ULA_CTRL_ICOUNT_EN
    // Saturation: preload near the top, then retire two NOPs.
    @(posedge clock);
    #1;
    force dut.r_icount = 16'hFFFE;
    release dut.r_icount;
    icnt_model = 16'hFFFE;
    step("sat_run1", 1'b1, 1'b1, 16'h6000, idle_v(1'b1));
    step("sat_dec1", 1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h00, 5'b00000, 3'b111, 1, 1));
    step("sat_run2", 1'b1, 1'b1, 16'h6000, idle_v(1'b1));
    step("sat_dec2", 1'b1, 1'b0, 16'h0000, ev(0, 8'h00, 8'h00, 5'b00000, 3'b111, 1, 1));
    step("sat_idle", 1'b1, 1'b0, 16'h0000, idle_v(1'b0));
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sat_drain: got=%0d entries pending want=0", exp_q.size());
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
